// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word at a time and hands it to decode.
// Optional macro IFU_MISALIGN_TRAP_EN adds a sticky misaligned-PC trap (ERR state).
module ifu_fetch #(
    parameter int unsigned              ISA_WIDTH = 32,
    parameter logic [ISA_WIDTH-1:0]     RESET_PC  = ISA_WIDTH'(32'h8000_0000)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ISA_WIDTH-1:0] pc_in,
    input  logic                 pc_w_en,
    output logic [ISA_WIDTH-1:0] pc_out,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [ISA_WIDTH-1:0] imem_addr,
    input  logic                 imem_rsp_valid,
    input  logic [31:0]          imem_rsp_data,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [31:0]          inst,
    output logic [ISA_WIDTH-1:0] inst_pc,
    output logic                 fetch_err
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        EXEC
`ifdef IFU_MISALIGN_TRAP_EN
        , ERR
`endif
    } state_t;

    state_t               state;
    logic [ISA_WIDTH-1:0] pc;
    logic                 req_valid_q;
    logic                 inst_valid_q;
    logic [31:0]          inst_q;
    logic [ISA_WIDTH-1:0] inst_pc_q;
`ifdef IFU_MISALIGN_TRAP_EN
    logic                 err_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= RESET_PC;
`ifdef IFU_MISALIGN_TRAP_EN
            err_q        <= 1'b0;
`endif
        end else begin
            // Output flags are set on the transition into the state that owns them.
            case (state)
                IDLE: begin
                    state       <= REQ;
                    req_valid_q <= 1'b1;
                end
                REQ: begin
                    if (imem_req_ready) begin
                        state       <= WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        inst_q       <= imem_rsp_data;
                        inst_pc_q    <= pc;
                        inst_valid_q <= 1'b1;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        inst_valid_q <= 1'b0;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    if (pc_w_en) begin
                        pc <= pc_in;
`ifdef IFU_MISALIGN_TRAP_EN
                        if (pc_in[1:0] != 2'b00) begin
                            err_q <= 1'b1;
                            state <= ERR;
                        end else begin
                            req_valid_q <= 1'b1;
                            state       <= REQ;
                        end
`else
                        req_valid_q <= 1'b1;
                        state       <= REQ;
`endif
                    end
                end
`ifdef IFU_MISALIGN_TRAP_EN
                ERR: begin
                    state <= ERR;
                end
`endif
                default: begin
                    state        <= IDLE;
                    req_valid_q  <= 1'b0;
                    inst_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out         = pc;
    assign imem_addr      = pc;
    assign imem_req_valid = req_valid_q;
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
`ifdef IFU_MISALIGN_TRAP_EN
    assign fetch_err      = err_q;
`else
    assign fetch_err      = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Vector-table bench for ifu_fetch: per-cycle inputs with hand-derived expected outputs.
module tb_ifu_fetch;

    localparam logic [31:0] A = 32'h8000_0000;
`ifdef IFU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_in = '0;
    logic        pc_w_en = 1'b0;
    logic [31:0] pc_out;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_err;

    always #5 clk = ~clk;

    ifu_fetch #(.ISA_WIDTH(32), .RESET_PC(32'h8000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_w_en        (pc_w_en),
        .pc_out         (pc_out),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fetch_err      (fetch_err)
    );

    typedef struct {
        logic        r;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        ir;
        logic        we;
        logic [31:0] pin;
        logic        eqv;
        logic [31:0] ea;
        logic        eiv;
        logic [31:0] ei;
        logic [31:0] eip;
        logic        ee;
    } vec_t;

    typedef struct {
        logic        eqv;
        logic [31:0] ea;
        logic        eiv;
        logic [31:0] ei;
        logic [31:0] eip;
        logic        ee;
    } exp_t;

    vec_t tbl[$];
    vec_t seq2[$];
    vec_t seq3[$];
    exp_t sb[$];
    int   n_applied = 0;
    int   n_miscompare = 0;

    function automatic vec_t mk(logic r, logic rdy, logic rv, logic [31:0] rd, logic ir,
                                logic we, logic [31:0] pin, logic eqv, logic [31:0] ea,
                                logic eiv, logic [31:0] ei, logic [31:0] eip, logic ee);
        vec_t v;
        v.r = r; v.rdy = rdy; v.rv = rv; v.rd = rd; v.ir = ir; v.we = we; v.pin = pin;
        v.eqv = eqv; v.ea = ea; v.eiv = eiv; v.ei = ei; v.eip = eip; v.ee = ee;
        return v;
    endfunction

    task automatic check(input string name, input exp_t e);
        n_applied++;
        if (imem_req_valid !== e.eqv || imem_addr !== e.ea || pc_out !== e.ea ||
            inst_valid !== e.eiv || inst !== e.ei || inst_pc !== e.eip || fetch_err !== e.ee) begin
            n_miscompare++;
            $display("FAIL %s: got req_valid=%b addr=%h pc_out=%h inst_valid=%b inst=%h inst_pc=%h err=%b; want req_valid=%b addr=%h inst_valid=%b inst=%h inst_pc=%h err=%b",
                     name, imem_req_valid, imem_addr, pc_out, inst_valid, inst, inst_pc, fetch_err,
                     e.eqv, e.ea, e.eiv, e.ei, e.eip, e.ee);
        end
    endtask

    task automatic apply(input string name, input vec_t v);
        exp_t e;
        @(negedge clk);
        rst            = v.r;
        imem_req_ready = v.rdy;
        imem_rsp_valid = v.rv;
        imem_rsp_data  = v.rd;
        inst_ready     = v.ir;
        pc_w_en        = v.we;
        pc_in          = v.pin;
        e.eqv = v.eqv; e.ea = v.ea; e.eiv = v.eiv; e.ei = v.ei; e.eip = v.eip; e.ee = v.ee;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check(name, sb.pop_front());
    endtask

    initial begin
        exp_t e;
        // Row = inputs before an edge, expected outputs after it.
        tbl.push_back(mk(0,0,0,0,0,0,0,               0,A,0,0,A,0));         // reset
        tbl.push_back(mk(0,1,1,32'h1,1,1,32'h4,       0,A,0,0,A,0));         // inputs ignored in reset
        tbl.push_back(mk(1,1,0,0,0,0,0,               1,A,0,0,A,0));         // IDLE->REQ
        tbl.push_back(mk(1,1,0,0,0,0,0,               0,A,0,0,A,0));         // accepted ->WAIT
        tbl.push_back(mk(1,0,1,32'h13,0,0,0,          0,A,1,32'h13,A,0));    // rsp ->HOLD
        tbl.push_back(mk(1,0,0,0,1,0,0,               0,A,0,32'h13,A,0));    // ->EXEC
        tbl.push_back(mk(1,0,0,0,0,1,A+4,             1,A+4,0,32'h13,A,0));  // pc write ->REQ
        tbl.push_back(mk(1,0,0,0,0,0,0,               1,A+4,0,32'h13,A,0));  // req stall 1
        tbl.push_back(mk(1,0,1,32'hBAD,0,1,32'hDEAD_BEEC, 1,A+4,0,32'h13,A,0)); // stall 2, stray we/rsp
        tbl.push_back(mk(1,0,0,0,0,0,0,               1,A+4,0,32'h13,A,0));  // stall 3
        tbl.push_back(mk(1,1,0,0,0,0,0,               0,A+4,0,32'h13,A,0));  // ->WAIT
        tbl.push_back(mk(1,0,0,0,0,0,0,               0,A+4,0,32'h13,A,0));  // WAIT, no rsp
        tbl.push_back(mk(1,0,1,32'h0010_0073,0,0,0,   0,A+4,1,32'h0010_0073,A+4,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,               0,A+4,1,32'h0010_0073,A+4,0));
        tbl.push_back(mk(1,0,1,32'hFFFF_FFFF,0,0,0,   0,A+4,1,32'h0010_0073,A+4,0)); // stray rsp
        tbl.push_back(mk(1,0,0,0,0,1,32'h1234_5678,   0,A+4,1,32'h0010_0073,A+4,0)); // HOLD we ignored
        tbl.push_back(mk(1,0,0,0,0,0,0,               0,A+4,1,32'h0010_0073,A+4,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,               0,A+4,1,32'h0010_0073,A+4,0));
        tbl.push_back(mk(1,0,0,0,1,0,0,               0,A+4,0,32'h0010_0073,A+4,0)); // ->EXEC
        tbl.push_back(mk(1,1,0,0,0,0,0,               0,A+4,0,32'h0010_0073,A+4,0)); // EXEC wait
        tbl.push_back(mk(1,0,0,0,0,1,A+32'h10,        1,A+32'h10,0,32'h0010_0073,A+4,0));
        tbl.push_back(mk(1,1,0,0,0,0,0,               0,A+32'h10,0,32'h0010_0073,A+4,0));
        tbl.push_back(mk(1,0,1,32'h93,0,0,0,          0,A+32'h10,1,32'h93,A+32'h10,0));
        tbl.push_back(mk(1,0,0,0,1,0,0,               0,A+32'h10,0,32'h93,A+32'h10,0));
        tbl.push_back(mk(1,0,0,0,0,1,A+32'h20,        1,A+32'h20,0,32'h93,A+32'h10,0)); // 4-cycle loop
        tbl.push_back(mk(1,1,0,0,0,0,0,               0,A+32'h20,0,32'h93,A+32'h10,0)); // WAIT
        tbl.push_back(mk(0,0,1,32'hDEAD,0,0,0,        0,A,0,0,A,0));         // reset in WAIT
        tbl.push_back(mk(1,0,1,32'hDEAD,0,0,0,        1,A,0,0,A,0));         // in-flight rsp ignored
        tbl.push_back(mk(1,0,1,32'hDEAD,0,0,0,        1,A,0,0,A,0));
        tbl.push_back(mk(1,1,0,0,0,0,0,               0,A,0,0,A,0));
        tbl.push_back(mk(1,0,1,32'h113,0,0,0,         0,A,1,32'h113,A,0));
        tbl.push_back(mk(1,0,0,0,1,0,0,               0,A,0,32'h113,A,0));
        tbl.push_back(mk(1,0,0,0,0,1,A+2,             !TRAP,A+2,0,32'h113,A,TRAP)); // misaligned
        tbl.push_back(mk(1,1,0,0,0,0,0,               0,A+2,0,32'h113,A,TRAP));
        tbl.push_back(mk(1,0,1,32'h213,0,0,0,         0,A+2,!TRAP,TRAP ? 32'h113 : 32'h213,
                         TRAP ? A : A+2,TRAP));

        seq2.push_back(mk(0,0,0,0,0,0,0,              0,A,0,0,A,0));
        seq2.push_back(mk(1,1,0,0,0,0,0,              1,A,0,0,A,0));
        seq2.push_back(mk(1,1,0,0,0,0,0,              0,A,0,0,A,0));
        seq2.push_back(mk(1,0,1,32'h333,0,0,0,        0,A,1,32'h333,A,0));
        seq2.push_back(mk(1,0,0,0,1,0,0,              0,A,0,32'h333,A,0));
        seq2.push_back(mk(1,0,0,0,0,1,A+8,            1,A+8,0,32'h333,A,0));
        seq2.push_back(mk(1,1,0,0,0,0,0,              0,A+8,0,32'h333,A,0));   // in WAIT

        seq3.push_back(mk(1,0,1,32'h555,0,0,0,        1,A,0,0,A,0));
        seq3.push_back(mk(1,1,0,0,0,0,0,              0,A,0,0,A,0));
        seq3.push_back(mk(1,0,1,32'h777,0,0,0,        0,A,1,32'h777,A,0));

        foreach (tbl[i]) apply($sformatf("tbl[%0d]", i), tbl[i]);
        foreach (seq2[i]) apply($sformatf("seq2[%0d]", i), seq2[i]);

        // Asynchronous reset mid-cycle while in WAIT: outputs must clear before any edge.
        @(negedge clk);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h444;
        #1 rst = 1'b0;
        #1;
        e.eqv = 0; e.ea = A; e.eiv = 0; e.ei = 0; e.eip = A; e.ee = 0;
        sb.push_back(e);
        check("async_rst", sb.pop_front());

        foreach (seq3[i]) apply($sformatf("seq3[%0d]", i), seq3[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
        $finish;
    end

endmodule
